// File: rtl/classifier_model_loader.sv
// classifier_model_loader
//   Sequences model loading for the linear SVM classifier. It validates a framed,
//   checksummed model packet arriving from the BLE UART and forwards its payload
//   to the classifier. On a checksum failure or a stalled packet it resynchronises
//   the classifier with a one-cycle reset pulse. It also gates predict_enable so
//   that predictions only start on a feature-frame boundary, and only while a
//   validated model is loaded.
//
//   Packet: SYNC, N, N*2*(NUM_FEATURES_IN-1) coefficient bytes, 4 offset bytes, CK
//           CK = XOR of every byte from N through the last offset byte.
//
// Ports
//   clk_in              system clock
//   rst_n_in            asynchronous active-low reset (shared with the classifier)
//   ble_data_in         byte from the BLE UART
//   ble_valid_in        one-cycle strobe per byte
//   feature_valid_in    feature word strobe (same bus the classifier sees)
//   feature_last_in     last word of the feature frame
//   predict_request_in  system wants predictions
//   clf_data_out        forwarded byte to the classifier
//   clf_valid_out       forwarded byte strobe
//   clf_rst_out         one-cycle classifier resync pulse
//   predict_enable_out  classifier predict enable
//   model_valid_out     a validated model is resident
//   load_busy_out       a packet is in progress
//   load_error_out      last packet failed (sticky until the next SYNC)
module classifier_model_loader #(
  parameter int         NUM_FEATURES_IN = 16,
  parameter int         TIMEOUT_CYCLES  = 1000000,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] ble_data_in,
  input  logic       ble_valid_in,
  input  logic       feature_valid_in,
  input  logic       feature_last_in,
  input  logic       predict_request_in,
  output logic [7:0] clf_data_out,
  output logic       clf_valid_out,
  output logic       clf_rst_out,
  output logic       predict_enable_out,
  output logic       model_valid_out,
  output logic       load_busy_out,
  output logic       load_error_out
);

  localparam int CW = $clog2(255 * 2 * (NUM_FEATURES_IN - 1) + 5);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COEF_PER_SV = CW'(2 * (NUM_FEATURES_IN - 1));

  typedef enum logic [1:0] {IDLE, COUNT, PAYLOAD, CHECK} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_rem;
  logic [7:0]    r_acc;
  logic [TW-1:0] r_idle;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_rst;
  logic          r_pe;
  logic          r_mv;
  logic          r_err;
  logic          r_frame;

  logic          w_fwd;
  logic          w_err_set;
  logic          w_err_clr;
  logic          w_mv_set;
  logic          w_mv_clr;
  logic          w_pulse;
  logic          w_rem_load;
  logic          w_rem_dec;
  logic          w_acc_load;
  logic          w_acc_upd;
  logic          w_timeout;
  logic          w_target;
  logic [CW-1:0] w_rem_init;

  // Bytes still expected after N: all coefficients plus the 4 offset bytes.
  assign w_rem_init = CW'(ble_data_in) * COEF_PER_SV + CW'(4);

  // A byte arriving on the timeout cycle wins over the timeout.
  assign w_timeout = (r_state != IDLE) && !ble_valid_in && (r_idle == TO_LAST);

  always_comb begin
    w_next     = r_state;
    w_fwd      = 1'b0;
    w_err_set  = 1'b0;
    w_err_clr  = 1'b0;
    w_mv_set   = 1'b0;
    w_mv_clr   = 1'b0;
    w_pulse    = 1'b0;
    w_rem_load = 1'b0;
    w_rem_dec  = 1'b0;
    w_acc_load = 1'b0;
    w_acc_upd  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ble_valid_in && ble_data_in == SYNC_BYTE) begin
          w_next    = COUNT;
          w_err_clr = 1'b1;
        end
      end
      COUNT: begin
        if (ble_valid_in) begin
          if (ble_data_in == 8'h00) begin
            w_err_set = 1'b1;
            w_next    = IDLE;
          end else begin
            w_fwd      = 1'b1;
            w_rem_load = 1'b1;
            w_acc_load = 1'b1;
            w_mv_clr   = 1'b1;
            w_next     = PAYLOAD;
          end
        end else if (w_timeout) begin
          // Nothing forwarded yet, so the classifier needs no resync.
          w_err_set = 1'b1;
          w_next    = IDLE;
        end
      end
      PAYLOAD: begin
        if (ble_valid_in) begin
          w_fwd     = 1'b1;
          w_rem_dec = 1'b1;
          w_acc_upd = 1'b1;
          if (r_rem == CW'(1)) w_next = CHECK;
        end else if (w_timeout) begin
          w_err_set = 1'b1;
          w_pulse   = 1'b1;
          w_next    = IDLE;
        end
      end
      CHECK: begin
        if (ble_valid_in) begin
          if (ble_data_in == r_acc) begin
            w_mv_set = 1'b1;
          end else begin
            w_err_set = 1'b1;
            w_pulse   = 1'b1;
          end
          w_next = IDLE;
        end else if (w_timeout) begin
          w_err_set = 1'b1;
          w_pulse   = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rem   <= '0;
      r_acc   <= '0;
      r_idle  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_rst   <= 1'b0;
      r_mv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_next == IDLE || ble_valid_in) r_idle <= '0;
      else                                r_idle <= r_idle + TW'(1);

      if (w_rem_load)     r_rem <= w_rem_init;
      else if (w_rem_dec) r_rem <= r_rem - CW'(1);

      if (w_acc_load)     r_acc <= ble_data_in;
      else if (w_acc_upd) r_acc <= r_acc ^ ble_data_in;

      r_valid <= w_fwd;
      if (w_fwd) r_data <= ble_data_in;
      r_rst <= w_pulse;

      if (w_mv_set)      r_mv <= 1'b1;
      else if (w_mv_clr) r_mv <= 1'b0;

      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  // Predictions may stop at any time but only start between feature frames.
  assign w_target = predict_request_in && r_mv && (r_state == IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame <= 1'b0;
      r_pe    <= 1'b0;
    end else begin
      if (feature_valid_in) r_frame <= !feature_last_in;
      if (!w_target)                               r_pe <= 1'b0;
      else if (!r_frame && !feature_valid_in)      r_pe <= 1'b1;
    end
  end

  assign clf_data_out       = r_data;
  assign clf_valid_out      = r_valid;
  assign clf_rst_out        = r_rst;
  assign predict_enable_out = r_pe;
  assign model_valid_out    = r_mv;
  assign load_busy_out      = (r_state != IDLE);
  assign load_error_out     = r_err;

endmodule

// File: tb/tb_classifier_model_loader.sv
module tb_classifier_model_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ble_data = 8'h00;
  logic       ble_valid = 1'b0;
  logic       fv = 1'b0;
  logic       fl = 1'b0;
  logic       req = 1'b0;
  logic [7:0] clf_data;
  logic       clf_valid;
  logic       clf_rst;
  logic       pe;
  logic       mv;
  logic       busy;
  logic       err;

  classifier_model_loader #(
    .NUM_FEATURES_IN (16),
    .TIMEOUT_CYCLES  (100),
    .SYNC_BYTE       (8'hA5)
  ) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .ble_data_in        (ble_data),
    .ble_valid_in       (ble_valid),
    .feature_valid_in   (fv),
    .feature_last_in    (fl),
    .predict_request_in (req),
    .clf_data_out       (clf_data),
    .clf_valid_out      (clf_valid),
    .clf_rst_out        (clf_rst),
    .predict_enable_out (pe),
    .model_valid_out    (mv),
    .load_busy_out      (busy),
    .load_error_out     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Drives one byte for one cycle; forwarded bytes are queued with the
  // cycle at which they must appear on clf_data_out.
  task automatic send_byte(input logic [7:0] b, input bit fwd);
    exp_t e;
    ble_data  = b;
    ble_valid = 1'b1;
    if (fwd) begin
      e.d = b;
      e.c = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ble_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit bad_ck);
    logic [7:0] ck;
    logic [7:0] b;
    send_byte(8'hA5, 1'b0);
    send_byte(n[7:0], 1'b1);
    ck = n[7:0];
    for (int i = 0; i < n * 30 + 4; i++) begin
      b  = 8'(8'h10 + i);
      ck = ck ^ b;
      send_byte(b, 1'b1);
    end
    if (bad_ck) ck = ck ^ 8'h01;
    send_byte(ck, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int c0;
    logic pe_bad;

    fork
      begin : monitor
        exp_t e;
        logic prev_rst;
        prev_rst = 1'b0;
        forever begin
          @(negedge clk);
          if (clf_valid) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_fwd: got byte %0h, required no output", clf_data);
            end else begin
              e = exp_q.pop_front();
              chk("fwd_data", 32'(clf_data), 32'(e.d));
              chk("fwd_latency", cyc, e.c);
            end
          end
          if (clf_rst && prev_rst) begin
            n_vec++;
            n_err++;
            $display("FAIL rst_width: clf_rst_out high 2 cycles, required 1");
          end
          if (clf_rst) pulses++;
          prev_rst = clf_rst;
        end
      end
    join_none

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clf_data", 32'(clf_data), 0);
    chk("rst_clf_valid", 32'(clf_valid), 0);
    chk("rst_clf_rst", 32'(clf_rst), 0);
    chk("rst_pe", 32'(pe), 0);
    chk("rst_mv", 32'(mv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    // Good packet
    p0 = pulses;
    send_pkt(1, 1'b0);
    chk("good_mv", 32'(mv), 1);
    chk("good_busy", 32'(busy), 0);
    chk("good_err", 32'(err), 0);
    wait_cycles(2);
    chk("good_no_pulse", pulses - p0, 0);
    chk("good_all_fwd", exp_q.size(), 0);

    // Bad checksum
    p0 = pulses;
    send_pkt(1, 1'b1);
    chk("badck_mv", 32'(mv), 0);
    chk("badck_err", 32'(err), 1);
    chk("badck_busy", 32'(busy), 0);
    wait_cycles(3);
    chk("badck_one_pulse", pulses - p0, 1);

    // N == 0 after a good load
    send_pkt(1, 1'b0);
    p0 = pulses;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("n0_err", 32'(err), 1);
    chk("n0_mv", 32'(mv), 1);
    chk("n0_busy", 32'(busy), 0);
    wait_cycles(2);
    chk("n0_no_pulse", pulses - p0, 0);

    // Timeout mid-payload
    p0 = pulses;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b1);
    c0 = cyc;
    for (int k = 0; k < 150 && !err; k++) @(negedge clk);
    chk("to_cycles", cyc - c0, 100);
    chk("to_pulse_level", 32'(clf_rst), 1);
    wait_cycles(2);
    chk("to_one_pulse", pulses - p0, 1);
    chk("to_mv", 32'(mv), 0);
    chk("to_busy", 32'(busy), 0);

    // Byte on cycle 99 keeps the packet alive
    p0 = pulses;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i), 1'b1);
    repeat (98) @(posedge clk);
    #1;
    send_byte(8'h77, 1'b1);
    wait_cycles(6);
    chk("late_err", 32'(err), 0);
    chk("late_busy", 32'(busy), 1);
    chk("late_no_pulse", pulses - p0, 0);
    wait_cycles(110);
    chk("late_then_to_err", 32'(err), 1);
    chk("late_then_to_pulse", pulses - p0, 1);

    // Predict gating
    send_pkt(1, 1'b0);
    pe_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fv = 1'b1;
      fl = (i == 15);
      @(posedge clk);
      #1;
      if (i == 2) req = 1'b1;
      if (i < 15) pe_bad = pe_bad | pe;
    end
    fv = 1'b0;
    fl = 1'b0;
    chk("pe_midframe", 32'(pe_bad), 0);
    chk("pe_at_last", 32'(pe), 0);
    wait_cycles(1);
    chk("pe_after_frame", 32'(pe), 1);
    send_byte(8'hA5, 1'b0);
    chk("pe_load_start_busy", 32'(busy), 1);
    chk("pe_hold_one_cycle", 32'(pe), 1);
    send_byte(8'h01, 1'b1);
    chk("pe_drop", 32'(pe), 0);

    // Reset mid-payload
    for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i), 1'b1);
    p0 = pulses;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clf_data", 32'(clf_data), 0);
    chk("mid_rst_clf_valid", 32'(clf_valid), 0);
    chk("mid_rst_clf_rst", 32'(clf_rst), 0);
    chk("mid_rst_pe", 32'(pe), 0);
    chk("mid_rst_mv", 32'(mv), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    req = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);
    send_pkt(1, 1'b0);
    chk("post_rst_mv", 32'(mv), 1);
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_busy", 32'(busy), 0);
    wait_cycles(3);
    chk("post_rst_no_pulse", pulses - p0, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
